servo_slew_pwm: RTL and testbench



---
 rtl/servo_slew_pwm_if.sv | 29 ++
 rtl/servo_slew_pwm.sv | 93 +++++++++
 tb/tb_servo_slew_pwm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/servo_slew_pwm_if.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew_pwm_if
// Description : Aim-target bus and servo status bus for servo_slew_pwm.
// Revision    : 1.0 - initial release
// ============================================================================
interface servo_slew_pwm_if;
    logic [7:0] target_x;
    logic [7:0] target_y;
    logic       target_valid;
    logic       hold;
    logic       servo_pwm_out_x;
    logic       servo_pwm_out_y;
    logic [7:0] cur_x;
    logic [7:0] cur_y;
    logic       settled;
    logic       frame_tick;

    modport master (
        output target_x, target_y, target_valid, hold,
        input  servo_pwm_out_x, servo_pwm_out_y, cur_x, cur_y, settled, frame_tick
    );

    modport slave (
        input  target_x, target_y, target_valid, hold,
        output servo_pwm_out_x, servo_pwm_out_y, cur_x, cur_y, settled, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/servo_slew_pwm.sv
`default_nettype none
// ============================================================================
// Module      : servo_slew_pwm
// Description : Slew-limited X/Y servo positioner with glitch-free 50 Hz PWM.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_slew_pwm #(
    parameter int unsigned FRAME_CYCLES = 1000000,
    parameter int unsigned PULSE_MIN    = 25000,
    parameter int unsigned PULSE_STEP   = 294,
    parameter int unsigned MAX_STEP     = 4,
    parameter int unsigned RESET_POS    = 128
) (
    input  wire               clk50mhz,
    input  wire               rst,
    servo_slew_pwm_if.slave   bus
);

    localparam logic [19:0] c_cnt_last  = 20'(FRAME_CYCLES - 1);
    localparam logic [7:0]  c_pos_rst   = 8'(RESET_POS);
    localparam logic [19:0] c_pulse_rst = 20'(PULSE_MIN + RESET_POS * PULSE_STEP);
    localparam logic [7:0]  c_step8     = 8'(MAX_STEP);
    localparam logic [8:0]  c_step9     = 9'(MAX_STEP);

    logic [19:0] r_cnt;
    logic [7:0]  r_tgt_x, r_tgt_y;
    logic [7:0]  r_cur_x, r_cur_y;
    logic [19:0] r_pulse_x, r_pulse_y;
    logic        r_pwm_x, r_pwm_y;
    logic        r_tick;

    logic        w_boundary;
    logic [7:0]  w_next_x, w_next_y;

    // Move one axis toward its target by at most MAX_STEP; the 9-bit signed
    // difference keeps the step direction exact across the full 0..255 range.
    function automatic logic [7:0] f_slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] diff;
        logic [8:0]        mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[8] ? 9'(-diff) : 9'(diff);
        if (mag <= c_step9)
            return tgt;
        else if (!diff[8])
            return cur + c_step8;
        else
            return cur - c_step8;
    endfunction

    assign w_boundary = (r_cnt == c_cnt_last);
    assign w_next_x   = bus.hold ? r_cur_x : f_slew(r_cur_x, r_tgt_x);
    assign w_next_y   = bus.hold ? r_cur_y : f_slew(r_cur_y, r_tgt_y);

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tgt_x   <= c_pos_rst;
            r_tgt_y   <= c_pos_rst;
            r_cur_x   <= c_pos_rst;
            r_cur_y   <= c_pos_rst;
            r_pulse_x <= c_pulse_rst;
            r_pulse_y <= c_pulse_rst;
            r_pwm_x   <= 1'b0;
            r_pwm_y   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt   <= w_boundary ? '0 : r_cnt + 20'd1;
            r_tick  <= w_boundary;
            r_pwm_x <= (r_cnt < r_pulse_x);
            r_pwm_y <= (r_cnt < r_pulse_y);
            if (bus.target_valid) begin
                r_tgt_x <= bus.target_x;
                r_tgt_y <= bus.target_y;
            end
            // Pulse widths only change here so a pulse is never cut mid-frame.
            if (w_boundary) begin
                r_cur_x   <= w_next_x;
                r_cur_y   <= w_next_y;
                r_pulse_x <= 20'(PULSE_MIN) + 20'(w_next_x) * 20'(PULSE_STEP);
                r_pulse_y <= 20'(PULSE_MIN) + 20'(w_next_y) * 20'(PULSE_STEP);
            end
        end
    end

    assign bus.servo_pwm_out_x = r_pwm_x;
    assign bus.servo_pwm_out_y = r_pwm_y;
    assign bus.cur_x           = r_cur_x;
    assign bus.cur_y           = r_cur_y;
    assign bus.frame_tick      = r_tick;
    assign bus.settled         = (r_cur_x == r_tgt_x) && (r_cur_y == r_tgt_y);

endmodule
`default_nettype wire

// File: tb/tb_servo_slew_pwm.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_slew_pwm
// Description : Self-checking bench for servo_slew_pwm against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_slew_pwm;

    localparam int c_frame = 1000;
    localparam int c_pmin  = 100;
    localparam int c_pstep = 2;
    localparam int c_max   = 4;
    localparam int c_rpos  = 128;

    logic clk50mhz = 1'b0;
    logic rst      = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    // Behavioural model: positions and targets as plain integers
    int m_cur_x, m_cur_y, m_tgt_x, m_tgt_y;

    servo_slew_pwm_if bus ();

    servo_slew_pwm #(
        .FRAME_CYCLES (c_frame),
        .PULSE_MIN    (c_pmin),
        .PULSE_STEP   (c_pstep),
        .MAX_STEP     (c_max),
        .RESET_POS    (c_rpos)
    ) dut (
        .clk50mhz (clk50mhz),
        .rst      (rst),
        .bus      (bus)
    );

    always #10 clk50mhz = ~clk50mhz;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int slew(input int cur, input int tgt);
        if (tgt - cur > c_max)  return cur + c_max;
        if (tgt - cur < -c_max) return cur - c_max;
        return tgt;
    endfunction

    function automatic int width(input int pos);
        return c_pmin + pos * c_pstep;
    endfunction

    function automatic int model_settled();
        return int'(m_cur_x == m_tgt_x && m_cur_y == m_tgt_y);
    endfunction

    task automatic tick_step();
        @(posedge clk50mhz);
        @(negedge clk50mhz);
    endtask

    // One full frame from the cnt==0 edge to the boundary edge. A strobe at
    // index c_frame-1 lands on the boundary edge itself.
    task automatic run_frame(input int sidx, input int tx, input int ty, input bit hd);
        int wx, wy, hx, hy, bad, ticks, tick_at;
        wx = width(m_cur_x);
        wy = width(m_cur_y);
        hx = 0; hy = 0; bad = 0; ticks = 0; tick_at = -1;
        bus.hold = hd;
        for (int i = 0; i < c_frame; i++) begin
            bus.target_valid = (i == sidx);
            bus.target_x     = 8'(tx);
            bus.target_y     = 8'(ty);
            tick_step();
            hx += int'(bus.servo_pwm_out_x);
            hy += int'(bus.servo_pwm_out_y);
            if (bus.servo_pwm_out_x !== (i < wx)) bad++;
            if (bus.servo_pwm_out_y !== (i < wy)) bad++;
            if (bus.frame_tick === 1'b1) begin ticks++; tick_at = i; end
            if (i == sidx && i < c_frame - 1) begin
                m_tgt_x = tx;
                m_tgt_y = ty;
                check("settled_mid", int'(bus.settled), model_settled());
            end
        end
        bus.target_valid = 1'b0;
        if (!hd) begin
            m_cur_x = slew(m_cur_x, m_tgt_x);
            m_cur_y = slew(m_cur_y, m_tgt_y);
        end
        if (sidx == c_frame - 1) begin
            m_tgt_x = tx;
            m_tgt_y = ty;
        end
        check("width_x", hx, wx);
        check("width_y", hy, wy);
        check("pwm_shape", bad, 0);
        check("tick_count", ticks, 1);
        check("tick_pos", tick_at, c_frame - 1);
        check("cur_x", int'(bus.cur_x), m_cur_x);
        check("cur_y", int'(bus.cur_y), m_cur_y);
        check("settled", int'(bus.settled), model_settled());
    endtask

    task automatic check_reset_state();
        check("rst_pwm_x", int'(bus.servo_pwm_out_x), 0);
        check("rst_pwm_y", int'(bus.servo_pwm_out_y), 0);
        check("rst_tick", int'(bus.frame_tick), 0);
        check("rst_cur_x", int'(bus.cur_x), c_rpos);
        check("rst_cur_y", int'(bus.cur_y), c_rpos);
        check("rst_settled", int'(bus.settled), 1);
    endtask

    initial begin
        bus.target_x = 8'd0;
        bus.target_y = 8'd0;
        bus.target_valid = 1'b0;
        bus.hold = 1'b0;
        m_cur_x = c_rpos; m_cur_y = c_rpos;
        m_tgt_x = c_rpos; m_tgt_y = c_rpos;

        // Reset, then idle frames at the reset position
        repeat (3) tick_step();
        check_reset_state();
        rst = 1'b0;
        repeat (3) run_frame(-1, 0, 0, 1'b0);
        check("idle_width_const", width(m_cur_x), 356);

        // Multi-step slew toward (140,116), captured mid-frame
        run_frame(10, 140, 116, 1'b0);
        repeat (3) run_frame(-1, 0, 0, 1'b0);
        check("slew_end_x", int'(bus.cur_x), 140);
        check("slew_end_y", int'(bus.cur_y), 116);

        // Return to 128, then a strobe on the boundary cycle itself
        run_frame(10, 128, 128, 1'b0);
        repeat (2) run_frame(-1, 0, 0, 1'b0);
        run_frame(c_frame - 1, 200, 200, 1'b0);
        check("bnd_keep_x", int'(bus.cur_x), 128);
        run_frame(-1, 0, 0, 1'b0);
        check("bnd_next_x", int'(bus.cur_x), 132);

        // Hold across two boundaries, then release
        repeat (2) run_frame(-1, 0, 0, 1'b1);
        run_frame(-1, 0, 0, 1'b0);
        check("hold_release_x", int'(bus.cur_x), 136);

        // Mid-frame reset while the outputs are high
        for (int i = 0; i < 300; i++) tick_step();
        check("pre_rst_pwm_x", int'(bus.servo_pwm_out_x), 1);
        rst = 1'b1;
        tick_step();
        check_reset_state();
        rst = 1'b0;
        m_cur_x = c_rpos; m_cur_y = c_rpos;
        m_tgt_x = c_rpos; m_tgt_y = c_rpos;
        run_frame(-1, 0, 0, 1'b0);

        // Sub-step jump, then walk to both range ends without wrapping
        run_frame(20, 130, 129, 1'b0);
        check("small_jump_x", int'(bus.cur_x), 130);
        run_frame(20, 0, 255, 1'b0);
        repeat (32) run_frame(-1, 0, 0, 1'b0);
        check("floor_x", int'(bus.cur_x), 0);
        check("ceil_y", int'(bus.cur_y), 255);
        run_frame(-1, 0, 0, 1'b0);

        // Randomized targets, strobe positions and hold
        repeat (8) begin
            int sidx;
            case ($urandom_range(0, 3))
                0:       sidx = -1;
                1:       sidx = c_frame - 1;
                default: sidx = int'($urandom_range(0, c_frame - 2));
            endcase
            run_frame(sidx, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
